// File: rtl/lockin_pkg.sv
`default_nettype none
// ============================================================
// lockin_pkg : shared types and constants for the lock-in loop controller
// Rev 1.0
// ============================================================
package lockin_pkg;

    localparam int DATA_W  = 8;
    localparam int STATE_W = 3;

    localparam logic [DATA_W-1:0] DEF_ACQ_GAIN = 8'd8;
    localparam logic [DATA_W-1:0] DEF_TRK_GAIN = 8'd2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ACQUIRE = 3'd2,
        TRACK   = 3'd3,
        LOCKED  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lockin_loop_ctrl_if.sv
`default_nettype none
// ============================================================
// lockin_loop_ctrl_if : detector/amplifier side signals of the loop controller
// Rev 1.0
// ============================================================
interface lockin_loop_ctrl_if;
    import lockin_pkg::*;

    logic                      start;
    logic                      abort;
    logic signed [DATA_W-1:0]  phase_err;
    logic                      err_valid;
    logic [DATA_W-1:0]         gain;
    logic                      gain_load;
    logic                      acc_clear;
    logic                      locked;
    logic                      lost_lock;
    logic                      timeout;
    logic [STATE_W-1:0]        state;

    modport master (
        output start, abort, phase_err, err_valid,
        input  gain, gain_load, acc_clear, locked, lost_lock, timeout, state
    );

    modport slave (
        input  start, abort, phase_err, err_valid,
        output gain, gain_load, acc_clear, locked, lost_lock, timeout, state
    );

endinterface
`default_nettype wire

// File: rtl/lockin_err_window.sv
`default_nettype none
// ============================================================
// lockin_err_window : registered |phase_err| window compare (one cycle latency)
// Rev 1.0
// ============================================================
module lockin_err_window
    import lockin_pkg::*;
#(
    parameter int LOCK_THRESH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     reset_n,
    input  wire logic                     sample_en,
    input  wire logic signed [DATA_W-1:0] phase_err,
    output logic                          in_win,
    output logic                          out_win
);

    localparam logic [DATA_W:0] c_THRESH = (DATA_W+1)'(LOCK_THRESH);

    logic [DATA_W:0] w_ext;
    logic [DATA_W:0] w_mag;

    // One extra bit so that the most negative sample has a representable magnitude
    assign w_ext = {phase_err[DATA_W-1], phase_err};
    assign w_mag = w_ext[DATA_W] ? ((DATA_W+1)'(0) - w_ext) : w_ext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_win  <= 1'b0;
            out_win <= 1'b0;
        end else begin
            in_win  <= sample_en && (w_mag <= c_THRESH);
            out_win <= sample_en && (w_mag >  c_THRESH);
        end
    end

endmodule
`default_nettype wire

// File: rtl/lockin_loop_ctrl.sv
`default_nettype none
// ============================================================
// lockin_loop_ctrl : acquisition / tracking / lock sequencer for the lock-in loop
// Rev 1.0
// ============================================================
module lockin_loop_ctrl
    import lockin_pkg::*;
#(
    parameter logic [DATA_W-1:0] ACQ_GAIN      = DEF_ACQ_GAIN,
    parameter logic [DATA_W-1:0] TRK_GAIN      = DEF_TRK_GAIN,
    parameter int                LOCK_THRESH   = 4,
    parameter int                LOCK_COUNT    = 16,
    parameter int                UNLOCK_COUNT  = 4,
    parameter int                SETTLE_CYCLES = 32,
    parameter int                TIMEOUT       = 1024
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    lockin_loop_ctrl_if.slave bus
);

    localparam int RUN_W    = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W   = $clog2(UNLOCK_COUNT + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W    = $clog2(TIMEOUT + 1);

    localparam logic [RUN_W-1:0]    c_RUN_MAX    = RUN_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0]   c_MISS_MAX   = MISS_W'(UNLOCK_COUNT);
    localparam logic [SETTLE_W-1:0] c_SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [TMO_W-1:0]    c_TMO_MAX    = TMO_W'(TIMEOUT);

    state_t                r_state,     w_state_nxt;
    logic [RUN_W-1:0]      r_run,       w_run_nxt;
    logic [MISS_W-1:0]     r_miss,      w_miss_nxt;
    logic [SETTLE_W-1:0]   r_settle,    w_settle_nxt;
    logic [TMO_W-1:0]      r_tmo,       w_tmo_nxt;
    logic [DATA_W-1:0]     r_gain,      w_gain_nxt;
    logic                  r_gain_load, w_gain_load_nxt;
    logic                  r_acc_clear, w_acc_clear_nxt;
    logic                  r_locked,    w_locked_nxt;
    logic                  r_lost_lock, w_lost_lock_nxt;
    logic                  r_timeout,   w_timeout_nxt;

    logic w_sample_en;
    logic w_in_win;
    logic w_out_win;

    // Only samples presented while ACQUIRE or LOCKED can ever be counted
    assign w_sample_en = bus.err_valid && ((r_state == ACQUIRE) || (r_state == LOCKED));

    lockin_err_window #(
        .LOCK_THRESH (LOCK_THRESH)
    ) u_err_window (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_en (w_sample_en),
        .phase_err (bus.phase_err),
        .in_win    (w_in_win),
        .out_win   (w_out_win)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_run       <= '0;
            r_miss      <= '0;
            r_settle    <= '0;
            r_tmo       <= '0;
            r_gain      <= ACQ_GAIN;
            r_gain_load <= 1'b0;
            r_acc_clear <= 1'b0;
            r_locked    <= 1'b0;
            r_lost_lock <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run       <= w_run_nxt;
            r_miss      <= w_miss_nxt;
            r_settle    <= w_settle_nxt;
            r_tmo       <= w_tmo_nxt;
            r_gain      <= w_gain_nxt;
            r_gain_load <= w_gain_load_nxt;
            r_acc_clear <= w_acc_clear_nxt;
            r_locked    <= w_locked_nxt;
            r_lost_lock <= w_lost_lock_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_run_nxt       = r_run;
        w_miss_nxt      = r_miss;
        w_settle_nxt    = r_settle;
        w_tmo_nxt       = r_tmo;
        w_gain_nxt      = r_gain;
        w_gain_load_nxt = 1'b0;
        w_acc_clear_nxt = 1'b0;
        w_locked_nxt    = r_locked;
        w_lost_lock_nxt = 1'b0;
        w_timeout_nxt   = r_timeout;

        if (bus.abort) begin
            w_state_nxt  = IDLE;
            w_run_nxt    = '0;
            w_miss_nxt   = '0;
            w_settle_nxt = '0;
            w_tmo_nxt    = '0;
            w_locked_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        w_state_nxt   = CLEAR;
                        w_timeout_nxt = 1'b0;
                    end
                end
                CLEAR: begin
                    w_run_nxt       = '0;
                    w_tmo_nxt       = '0;
                    w_settle_nxt    = '0;
                    w_acc_clear_nxt = 1'b1;
                    w_gain_nxt      = ACQ_GAIN;
                    w_gain_load_nxt = 1'b1;
                    w_state_nxt     = ACQUIRE;
                end
                ACQUIRE: begin
                    if (w_out_win)
                        w_run_nxt = '0;
                    else if (w_in_win && (r_run != c_RUN_MAX))
                        w_run_nxt = r_run + RUN_W'(1);
                    if (r_tmo != c_TMO_MAX)
                        w_tmo_nxt = r_tmo + TMO_W'(1);
                    // Reaching lock count takes precedence over a coincident timeout
                    if (w_run_nxt == c_RUN_MAX) begin
                        w_state_nxt     = TRACK;
                        w_gain_nxt      = TRK_GAIN;
                        w_gain_load_nxt = 1'b1;
                        w_settle_nxt    = '0;
                    end else if (w_tmo_nxt == c_TMO_MAX) begin
                        w_state_nxt   = IDLE;
                        w_timeout_nxt = 1'b1;
                        w_run_nxt     = '0;
                        w_tmo_nxt     = '0;
                    end
                end
                TRACK: begin
                    if (r_settle != c_SETTLE_MAX)
                        w_settle_nxt = r_settle + SETTLE_W'(1);
                    if (w_settle_nxt == c_SETTLE_MAX) begin
                        w_state_nxt  = LOCKED;
                        w_locked_nxt = 1'b1;
                        w_miss_nxt   = '0;
                    end
                end
                LOCKED: begin
                    if (w_in_win)
                        w_miss_nxt = '0;
                    else if (w_out_win && (r_miss != c_MISS_MAX))
                        w_miss_nxt = r_miss + MISS_W'(1);
                    if (w_miss_nxt == c_MISS_MAX) begin
                        w_state_nxt     = CLEAR;
                        w_locked_nxt    = 1'b0;
                        w_lost_lock_nxt = 1'b1;
                        w_miss_nxt      = '0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.state     = r_state;
    assign bus.gain      = r_gain;
    assign bus.gain_load = r_gain_load;
    assign bus.acc_clear = r_acc_clear;
    assign bus.locked    = r_locked;
    assign bus.lost_lock = r_lost_lock;
    assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_lockin_loop_ctrl.sv
`default_nettype none
// ============================================================
// tb_lockin_loop_ctrl : directed self-checking bench for lockin_loop_ctrl
// Rev 1.0
// ============================================================
module tb_lockin_loop_ctrl;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    lockin_loop_ctrl_if bus ();

    lockin_loop_ctrl u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic signed [7:0] v);
        bus.err_valid = 1'b1;
        bus.phase_err = v;
        step(1);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.phase_err = '0;
        bus.err_valid = 1'b0;
        step(2);
        chk("rst_state",     32'(bus.state), 0);
        chk("rst_gain",      32'(bus.gain), 8);
        chk("rst_gain_load", 32'(bus.gain_load), 0);
        chk("rst_acc_clear", 32'(bus.acc_clear), 0);
        chk("rst_locked",    32'(bus.locked), 0);
        chk("rst_lost_lock", 32'(bus.lost_lock), 0);
        chk("rst_timeout",   32'(bus.timeout), 0);
        reset_n = 1'b1;
        step(1);
        chk("idle_hold", 32'(bus.state), 0);

        // Clean acquisition
        bus.start = 1'b1;
        step(1);
        chk("acq_clear_state", 32'(bus.state), 1);
        bus.start = 1'b0;
        step(1);
        chk("acq_enter_state", 32'(bus.state), 2);
        chk("acq_acc_clear",   32'(bus.acc_clear), 1);
        chk("acq_gain_load",   32'(bus.gain_load), 1);
        chk("acq_gain",        32'(bus.gain), 8);
        bus.err_valid = 1'b1;
        bus.phase_err = 8'sd2;
        step(16);
        bus.err_valid = 1'b0;
        chk("acq_not_yet",      32'(bus.state), 2);
        chk("acq_no_gain_load", 32'(bus.gain_load), 0);
        step(1);
        chk("trk_state",     32'(bus.state), 3);
        chk("trk_gain_load", 32'(bus.gain_load), 1);
        chk("trk_gain",      32'(bus.gain), 2);
        step(1);
        chk("trk_strobe_1clk", 32'(bus.gain_load), 0);
        step(30);
        chk("trk_settling",  32'(bus.state), 3);
        chk("trk_no_lock",   32'(bus.locked), 0);
        step(1);
        chk("lock_state",    32'(bus.state), 4);
        chk("lock_locked",   32'(bus.locked), 1);

        // Loss of lock
        sample(8'sd9);
        sample(8'sd9);
        sample(8'sd1);
        sample(-8'sd20);
        sample(-8'sd20);
        sample(-8'sd20);
        chk("lol_hold_state",  32'(bus.state), 4);
        chk("lol_hold_locked", 32'(bus.locked), 1);
        sample(-8'sd20);
        chk("lol_3rd_locked",  32'(bus.locked), 1);
        bus.err_valid = 1'b0;
        step(1);
        chk("lol_state",      32'(bus.state), 1);
        chk("lol_lost_lock",  32'(bus.lost_lock), 1);
        chk("lol_locked",     32'(bus.locked), 0);
        step(1);
        chk("reacq_state",     32'(bus.state), 2);
        chk("reacq_acc_clear", 32'(bus.acc_clear), 1);
        chk("reacq_gain_load", 32'(bus.gain_load), 1);
        chk("reacq_gain",      32'(bus.gain), 8);
        chk("reacq_lost_1clk", 32'(bus.lost_lock), 0);

        // Run reset by out-of-window samples, including the most negative code
        bus.err_valid = 1'b1;
        bus.phase_err = 8'sd4;
        step(10);
        sample(-8'sd5);
        bus.phase_err = 8'sd0;
        step(15);
        sample(-8'sd128);
        sample(8'sd0);
        chk("run_reset_state", 32'(bus.state), 2);
        step(15);
        chk("run_before_16", 32'(bus.state), 2);
        bus.err_valid = 1'b0;
        step(1);
        chk("run_trk_state", 32'(bus.state), 3);
        chk("run_trk_gain",  32'(bus.gain), 2);

        // Abort during TRACK, abort beats start, start ignored in ACQUIRE
        bus.abort = 1'b1;
        step(1);
        chk("abort_state",     32'(bus.state), 0);
        chk("abort_gain_load", 32'(bus.gain_load), 0);
        chk("abort_acc_clear", 32'(bus.acc_clear), 0);
        chk("abort_gain_hold", 32'(bus.gain), 2);
        bus.start = 1'b1;
        step(1);
        chk("abort_start_idle", 32'(bus.state), 0);
        bus.abort = 1'b0;
        step(1);
        chk("restart_clear", 32'(bus.state), 1);
        bus.start = 1'b0;
        step(1);
        chk("restart_acq", 32'(bus.state), 2);
        bus.start = 1'b1;
        step(1);
        chk("start_in_acq_ignored", 32'(bus.state), 2);
        chk("start_in_acq_no_clr",  32'(bus.acc_clear), 0);
        bus.start = 1'b0;

        // Acquisition timeout
        bus.err_valid = 1'b1;
        bus.phase_err = 8'sd50;
        step(1022);
        chk("tmo_before_state", 32'(bus.state), 2);
        chk("tmo_before_flag",  32'(bus.timeout), 0);
        step(1);
        chk("tmo_state", 32'(bus.state), 0);
        chk("tmo_flag",  32'(bus.timeout), 1);
        step(1);
        chk("tmo_sticky", 32'(bus.timeout), 1);
        bus.start = 1'b1;
        step(1);
        chk("tmo_restart_state", 32'(bus.state), 1);
        chk("tmo_cleared",       32'(bus.timeout), 0);
        bus.start     = 1'b0;
        bus.phase_err = 8'sd0;

        // Reach LOCKED again, then reset asynchronously mid-cycle
        step(1);
        chk("relock_acq", 32'(bus.state), 2);
        step(16);
        bus.err_valid = 1'b0;
        step(1);
        chk("relock_trk", 32'(bus.state), 3);
        step(32);
        chk("relock_locked", 32'(bus.locked), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_state",  32'(bus.state), 0);
        chk("async_rst_locked", 32'(bus.locked), 0);
        chk("async_rst_gain",   32'(bus.gain), 8);
        step(1);
        reset_n = 1'b1;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lockin_loop_ctrl.md
Name: lockin_loop_ctrl

Overview:
- Sequencing controller for the feedback lock-in amplifier loop.
- Clears the feedback accumulator and loads a high acquisition gain, then watches the phase-error stream.
- Once the error stays small, it drops to a low tracking gain, lets the loop settle, and declares lock.
- In lock it detects loss of lock and re-acquires automatically. It sits beside the amplifier and drives its gain-load and accumulator-clear controls.

Parameters:
- ACQ_GAIN, 8, gain loaded during acquisition (8-bit unsigned).
- TRK_GAIN, 2, gain loaded for tracking/locked (8-bit unsigned).
- LOCK_THRESH, 4, maximum |phase_err| counted as "in window".
- LOCK_COUNT, 16, consecutive in-window samples needed to leave ACQUIRE.
- UNLOCK_COUNT, 4, consecutive out-of-window samples in LOCKED that declare loss of lock.
- SETTLE_CYCLES, 32, clocks spent in TRACK before LOCKED.
- TIMEOUT, 1024, maximum clocks in ACQUIRE before giving up.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request to begin acquisition; honoured only in IDLE.
- abort  in  1  forces return to IDLE; highest priority.
- phase_err  in  8  signed phase-error sample from the detector.
- err_valid  in  1  phase_err qualifier, one sample per asserted cycle.
- gain  out  8  gain value presented to the amplifier.
- gain_load  out  1  one-cycle strobe; the amplifier captures gain on it.
- acc_clear  out  1  one-cycle strobe; clears the feedback accumulator.
- locked  out  1  high while in LOCKED.
- lost_lock  out  1  one-cycle strobe on the LOCKED to CLEAR transition.
- timeout  out  1  sticky; set on acquisition timeout, cleared on the next accepted start.
- state  out  3  current FSM state encoding, for debug.

Behaviour:
- Reset is asynchronous on reset_n low and applies in any state. Reset values:
  - state = IDLE, gain = ACQ_GAIN.
  - gain_load, acc_clear, locked, lost_lock, timeout all 0.
  - All counters 0.
- All outputs are registered; strobes last exactly one clock.
- In-window test:
  - Magnitude is computed in 9 bits, so |-128| = 128 with no wrap.
  - in_win = err_valid and mag <= LOCK_THRESH.
  - out_win = err_valid and mag > LOCK_THRESH.
  - Cycles with err_valid = 0 leave all run counters unchanged.
- State encoding: IDLE = 0, CLEAR = 1, ACQUIRE = 2, TRACK = 3, LOCKED = 4.
- IDLE: start = 1 goes to CLEAR and clears timeout.
- CLEAR (exactly 1 cycle):
  - Registered outputs asserted the following cycle: acc_clear = 1, gain = ACQ_GAIN, gain_load = 1.
  - Zero run, timeout and settle counters; go to ACQUIRE.
  - Samples arriving in CLEAR are ignored.
- ACQUIRE:
  - in_win increments run; out_win zeroes run.
  - When run reaches LOCK_COUNT: go to TRACK, gain = TRK_GAIN, gain_load pulse.
  - Timeout counter increments every clock. At TIMEOUT clocks without reaching LOCK_COUNT: set timeout and go to IDLE.
  - If the lock-count and timeout conditions hit on the same cycle, lock wins.
- TRACK:
  - Errors are ignored.
  - After SETTLE_CYCLES clocks, go to LOCKED with locked = 1 and the miss counter zeroed.
- LOCKED:
  - out_win increments miss; in_win zeroes miss.
  - When miss reaches UNLOCK_COUNT: locked = 0, lost_lock pulse, go to CLEAR (automatic re-acquire).
- abort = 1 in any state goes to IDLE on the next clock:
  - locked = 0, no strobes that cycle.
  - Counters zeroed; gain holds its value; timeout unchanged.
  - abort together with start in IDLE stays in IDLE.
- start outside IDLE is ignored; a held start re-triggers after a timeout return to IDLE.
- Counters saturate at their terminal value. Each counter is sized to clog2 of its parameter + 1.
- Gain updates happen only together with a gain_load strobe.

Decomposition:
- Shared package lockin_pkg holds:
  - the state enum (IDLE, CLEAR, ACQUIRE, TRACK, LOCKED) and its 3-bit width;
  - the default gain constants (ACQ_GAIN, TRK_GAIN);
  - the 8-bit error/gain width constant.
- One natural sub-module, lockin_err_window: registered abs/compare of phase_err producing in_win/out_win.
  - It adds 1 cycle of latency, which all sample counts absorb uniformly.

Test Plan:
- Reset mid-LOCKED: drop reset_n asynchronously -> outputs immediately return to reset values: state = 0, locked = 0, gain = 8.
- Clean acquisition: start, then 16 valid samples of +2 -> acc_clear and gain_load (gain = 8) one cycle after CLEAR; gain_load with gain = 2 on the 16th sample; locked rises 32 clocks later.
- Run reset: 10 in-window samples, one sample of -5, then 16 samples of 0 -> TRACK entered only after the final 16; a -128 sample counts as out-of-window.
- Loss of lock: in LOCKED, samples +9, +9, +1, then 4 samples of -20 -> no loss after the first pair; lost_lock pulses and locked drops on the 4th -20; acc_clear follows one cycle later.
- Timeout: start with constant phase_err = 50 -> timeout = 1 and state = IDLE after 1024 ACQUIRE clocks; a new start clears timeout.
- Abort/priority: abort during TRACK -> IDLE next clock with no strobes; abort and start together in IDLE -> stays IDLE; start during ACQUIRE -> ignored.
